// File: rtl/pfqueue.sv
// pfqueue: pipelined instruction prefetch queue for the ZipCPU.
// Issues sequential Wishbone reads ahead of the CPU, buffers the returned
// words in a small FIFO, and hands them out in program order with their PCs.
// A new PC (or cache clear) flushes everything and aborts any bus cycle.
// A bus error turns into a sticky illegal-instruction output at the faulting PC.
`timescale 1ns/1ps
module pfqueue #(
   parameter int unsigned ADDRESS_WIDTH = 30,
   parameter int unsigned LGDEPTH       = 2,
   parameter bit          OPT_ALIGNED   = 1'b0
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_new_pc,
   input  logic                     i_clear_cache,
   input  logic                     i_ready,
   input  logic [ADDRESS_WIDTH+1:0] i_pc,
   output logic                     o_valid,
   output logic [31:0]              o_insn,
   output logic [ADDRESS_WIDTH+1:0] o_pc,
   output logic                     o_illegal,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   output logic                     o_wb_we,
   output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
   output logic [31:0]              o_wb_data,
   input  logic                     i_wb_stall,
   input  logic                     i_wb_ack,
   input  logic                     i_wb_err,
   input  logic [31:0]              i_wb_data
);

   localparam int unsigned AW    = ADDRESS_WIDTH;
   localparam int unsigned DEPTH = 1 << LGDEPTH;
   localparam int unsigned CW    = LGDEPTH + 1;
   // Queue depth, one bit wider than the counters so count sums never overflow
   localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                cyc_q, cyc_d;
   logic                stb_q, stb_d;
   logic [AW-1:0]       req_addr_q, req_addr_d;
   logic [CW-1:0]       inflight_q, inflight_d;
   logic [CW-1:0]       fill_q, fill_d;
   logic [AW+1:0]       out_pc_q, out_pc_d;
   logic [LGDEPTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LGDEPTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0]         mem_q [DEPTH];

   logic                accept;
   logic                ack;
   logic                bus_err;
   logic                pop;
   logic                push;

   // Next-state logic: flush handling, bus request pacing, FIFO bookkeeping
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      req_addr_d = req_addr_q;
      inflight_d = inflight_q;
      fill_d     = fill_q;
      out_pc_d   = out_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      push       = 1'b0;

      // Responses only count while our cycle is open; err takes precedence over ack
      accept  = cyc_q && stb_q && !i_wb_stall;
      ack     = cyc_q && i_wb_ack && !i_wb_err;
      bus_err = cyc_q && i_wb_err;
      pop     = (fill_q != '0) && i_ready;

      if (i_new_pc || i_clear_cache) begin
         // Flush: anything requested or buffered belongs to the old stream
         fill_d     = '0;
         inflight_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         if (i_new_pc) begin
            state_d    = ST_FETCH;
            req_addr_d = i_pc[AW+1:2];
            out_pc_d   = i_pc;
            // An open cycle must close for one clock before a fresh one starts
            cyc_d      = !cyc_q;
            stb_d      = !cyc_q;
         end else begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
         end
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + LGDEPTH'(1);
            out_pc_d = {out_pc_q[AW+1:2] + AW'(1), 2'b00};
         end
         if (bus_err) begin
            // Abandon the cycle; buffered words still drain ahead of the fault
            state_d    = ST_ERROR;
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            inflight_d = '0;
            fill_d     = fill_q - CW'(pop);
         end else begin
            push       = ack;
            if (push) begin
               wr_ptr_d = wr_ptr_q + LGDEPTH'(1);
            end
            if (accept) begin
               req_addr_d = req_addr_q + AW'(1);
            end
            inflight_d = inflight_q + CW'(accept) - CW'(ack);
            fill_d     = fill_q + CW'(push) - CW'(pop);
            if (state_q == ST_FETCH) begin
               // Only ask for more while the next cycle's totals leave room
               stb_d = ({1'b0, inflight_d} + {1'b0, fill_d}) < DEPTH_C;
               cyc_d = stb_d || (inflight_d != '0);
            end else begin
               stb_d = 1'b0;
               cyc_d = 1'b0;
            end
         end
      end
   end

   // Control and address registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         req_addr_q <= '0;
         inflight_q <= '0;
         fill_q     <= '0;
         out_pc_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         req_addr_q <= req_addr_d;
         inflight_q <= inflight_d;
         fill_q     <= fill_d;
         out_pc_q   <= out_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Instruction storage; contents are qualified by the fill count
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_wb_data;
      end
   end

   assign o_valid   = (fill_q != '0) || (state_q == ST_ERROR);
   assign o_illegal = (state_q == ST_ERROR) && (fill_q == '0);
   assign o_insn    = (fill_q != '0) ? mem_q[rd_ptr_q] : 32'h0;
   assign o_pc      = OPT_ALIGNED ? {out_pc_q[AW+1:2], 2'b00} : out_pc_q;

   assign o_wb_cyc  = cyc_q;
   assign o_wb_stb  = stb_q;
   assign o_wb_we   = 1'b0;
   assign o_wb_addr = req_addr_q;
   assign o_wb_data = 32'h0;

endmodule

// File: tb/tb_pfqueue.sv
// Testbench for pfqueue: Wishbone slave model with random stall/latency/error,
// a reference model of the expected instruction stream, and a scoreboard monitor.
`timescale 1ns/1ps
module tb_pfqueue;

   localparam int AW      = 30;
   localparam int LGDEPTH = 2;
   localparam int DEPTH   = 1 << LGDEPTH;

   logic          clk;
   logic          i_reset, i_new_pc, i_clear_cache, i_ready;
   logic [AW+1:0] i_pc;
   logic          o_valid, o_illegal;
   logic [31:0]   o_insn;
   logic [AW+1:0] o_pc;
   logic          o_wb_cyc, o_wb_stb, o_wb_we;
   logic [AW-1:0] o_wb_addr;
   logic [31:0]   o_wb_data;
   logic          i_wb_stall, i_wb_ack, i_wb_err;
   logic [31:0]   i_wb_data;

   pfqueue #(.ADDRESS_WIDTH(AW), .LGDEPTH(LGDEPTH), .OPT_ALIGNED(1'b0)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_new_pc(i_new_pc),
      .i_clear_cache(i_clear_cache), .i_ready(i_ready), .i_pc(i_pc),
      .o_valid(o_valid), .o_insn(o_insn), .o_pc(o_pc), .o_illegal(o_illegal),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
      .i_wb_data(i_wb_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
      logic        ill;
   } exp_t;

   exp_t          expq[$];
   logic [AW-1:0] pend[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_pops   = 0;
   int            acc_cnt  = 0;
   int            ack_pct  = 100;
   int            stall_pct = 0;
   bit            rdy_rand = 0;
   logic          rdy_level = 1'b0;
   bit            err_en = 0;
   logic [AW-1:0] err_addr = '0;

   // Memory contents seen by the bus: a fixed function of the word address
   function automatic logic [31:0] memf(input logic [AW-1:0] w);
      return {w, 2'b01} ^ 32'h5A3C_96E1 ^ {w[15:0], w[29:14]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected stream after a new PC: sequential words, ending at a fault if one is planned
   task automatic load_model(input logic [31:0] pc);
      logic [AW-1:0] w;
      exp_t e;
      expq.delete();
      w = pc[31:2];
      for (int k = 0; k < 256; k++) begin
         e.pc   = (k == 0) ? pc : {w, 2'b00};
         e.ill  = err_en && (w == err_addr);
         e.insn = e.ill ? 32'h0 : memf(w);
         expq.push_back(e);
         if (e.ill) break;
         w = w + 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic new_pc(input logic [31:0] pc);
      step();
      load_model(pc);
      i_new_pc = 1'b1;
      i_pc     = pc;
      step();
      i_new_pc = 1'b0;
   endtask

   task automatic clear_cache();
      step();
      expq.delete();
      i_clear_cache = 1'b1;
      step();
      i_clear_cache = 1'b0;
   endtask

   // Wishbone slave: records accepted requests, answers in order after random delay
   initial begin
      logic          n_stall, n_ack, n_err;
      logic [31:0]   n_data;
      i_wb_stall = 1'b0;
      i_wb_ack   = 1'b0;
      i_wb_err   = 1'b0;
      i_wb_data  = 32'h0;
      i_ready    = 1'b0;
      forever begin
         @(negedge clk);
         if (!o_wb_cyc || i_reset) begin
            pend.delete();
         end else begin
            if ((i_wb_ack || i_wb_err) && pend.size() > 0) void'(pend.pop_front());
            if (o_wb_stb && !i_wb_stall) begin
               pend.push_back(o_wb_addr);
               acc_cnt++;
            end
            chk("inflight_bound", 32'(pend.size() <= DEPTH), 32'd1);
         end
         n_ack  = 1'b0;
         n_err  = 1'b0;
         n_data = 32'h0;
         if (o_wb_cyc && pend.size() > 0 && $urandom_range(99) < ack_pct) begin
            n_data = memf(pend[0]);
            if (err_en && pend[0] == err_addr) begin
               n_err = 1'b1;
               n_ack = 1'($urandom_range(1));
            end else begin
               n_ack = 1'b1;
            end
         end
         n_stall = ($urandom_range(99) < stall_pct);
         @(posedge clk);
         #2;
         i_wb_stall = n_stall;
         i_wb_ack   = n_ack;
         i_wb_err   = n_err;
         i_wb_data  = n_data;
         i_ready    = rdy_rand ? 1'($urandom_range(1)) : rdy_level;
      end
   end

   // Scoreboard monitor: every presented output must match the head of the expected stream
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!i_reset && !i_new_pc && !i_clear_cache && o_valid) begin
            if (expq.size() == 0) begin
               chk("unexpected_valid", 32'(o_valid), 32'd0);
            end else begin
               e = expq[0];
               chk("o_pc", o_pc, e.pc);
               chk("o_illegal", 32'(o_illegal), 32'(e.ill));
               if (!e.ill) chk("o_insn", o_insn, e.insn);
               if (i_ready && !e.ill) begin
                  void'(expq.pop_front());
                  n_pops++;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int nrun;
      logic [31:0] rpc;
      i_reset = 1'b1; i_new_pc = 1'b0; i_clear_cache = 1'b0; i_pc = '0;
      run(3);
      @(negedge clk);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_illegal", 32'(o_illegal), 0);
      chk("rst_cyc", 32'(o_wb_cyc), 0);
      chk("rst_stb", 32'(o_wb_stb), 0);
      chk("rst_we", 32'(o_wb_we), 0);
      chk("rst_wdata", o_wb_data, 0);
      chk("rst_insn", o_insn, 0);
      chk("rst_pc", o_pc, 0);
      chk("rst_addr", 32'(o_wb_addr), 0);
      step();
      i_reset = 1'b0;

      // Zero-wait bus, CPU always ready
      rdy_level = 1'b1;
      new_pc(32'h100);
      @(negedge clk);
      chk("first_stb", 32'(o_wb_stb), 1);
      chk("first_addr", 32'(o_wb_addr), 32'h40);
      chk("valid_n1", 32'(o_valid), 0);
      step();
      @(negedge clk);
      chk("valid_n2", 32'(o_valid), 0);
      step();
      @(negedge clk);
      chk("valid_n3", 32'(o_valid), 1);
      chk("pc_n3", o_pc, 32'h100);
      step();
      p0 = n_pops;
      run(40);
      chk("throughput", 32'(n_pops - p0), 40);

      // CPU stalled: queue fills, bus requests stop
      rdy_level = 1'b0;
      new_pc(32'h300);
      acc_cnt = 0;
      run(10);
      @(negedge clk);
      chk("full_accepts", 32'(acc_cnt), DEPTH);
      chk("full_stb_low", 32'(o_wb_stb), 0);
      chk("full_valid", 32'(o_valid), 1);
      chk("full_pc", o_pc, 32'h300);
      rdy_level = 1'b1;
      run(20);

      // Abort with requests outstanding; late acks must be ignored
      ack_pct = 0;
      new_pc(32'h100);
      run(5);
      ack_pct = 100;
      new_pc(32'h200);
      @(negedge clk);
      chk("abort_cyc_low", 32'(o_wb_cyc), 0);
      chk("abort_valid_low", 32'(o_valid), 0);
      step();
      @(negedge clk);
      chk("restart_stb", 32'(o_wb_stb), 1);
      chk("restart_addr", 32'(o_wb_addr), 32'h80);
      run(20);

      // Bus error on word 0x108
      err_en = 1; err_addr = 30'h42;
      new_pc(32'h100);
      p0 = n_pops;
      run(12);
      chk("err_pops", 32'(n_pops - p0), 2);
      rdy_level = 1'b0;
      run(3);
      @(negedge clk);
      chk("err_valid", 32'(o_valid), 1);
      chk("err_illegal", 32'(o_illegal), 1);
      chk("err_pc", o_pc, 32'h108);
      chk("err_cyc", 32'(o_wb_cyc), 0);
      rdy_level = 1'b1;
      run(5);
      err_en = 0;

      // Address wrap with random stall, latency and readiness
      stall_pct = 50; ack_pct = 70; rdy_rand = 1;
      new_pc(32'hFFFF_FFFC);
      p0 = n_pops;
      run(60);
      chk("wrap_progress", 32'(n_pops - p0 >= 3), 1);

      // Cache clear: idle until the next new PC
      rdy_rand = 0; rdy_level = 1'b1; stall_pct = 0; ack_pct = 100;
      new_pc(32'h500);
      run(5);
      clear_cache();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("clear_cyc", 32'(o_wb_cyc), 0);
         chk("clear_valid", 32'(o_valid), 0);
         step();
      end
      new_pc(32'h600);
      run(20);

      // Unaligned start PC
      new_pc(32'h102);
      run(15);

      // Randomized segments
      for (int it = 0; it < 10; it++) begin
         stall_pct = $urandom_range(60);
         ack_pct   = $urandom_range(30, 100);
         rdy_rand  = $urandom_range(1);
         rdy_level = 1'b1;
         rpc       = $urandom;
         if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
         err_en    = $urandom_range(1);
         err_addr  = rpc[31:2] + 30'($urandom_range(6));
         new_pc(rpc);
         nrun = $urandom_range(20, 80);
         run(nrun);
      end
      err_en = 0;
      run(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
